mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
- Controller that drives one MAC unit (sign-magnitude 8b x 8b, 21b accumulator with init/enable) through a fully-connected layer.
- For each neuron it clears the accumulator, walks all inputs, and streams data/weight memory addresses with 1-cycle read latency. It then captures the 21b sum and presents it on a valid/ready output toward the activation stage.
- Sits between the layer-level top controller (start/done) and the input buffer, weight ROM and MAC datapath.

Parameters:
- N_INPUTS, 64, inputs per neuron (>=2)
- N_NEURONS, 10, neurons in the layer (>=1)
- DATA_AW, 6, data address width, >= clog2(N_INPUTS)
- WEIGHT_AW, 10, weight address width, >= clog2(N_INPUTS*N_NEURONS)
- NEURON_W, 4, neuron index width, >= clog2(N_NEURONS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last neuron's result handshake
- dataAddr  out  DATA_AW  input buffer read address
- weightAddr  out  WEIGHT_AW  weight ROM read address
- macInit  out  1  to MAC init (clears accumulator)
- macEn  out  1  to MAC enMac (accumulate current product)
- macResult  in  21  MAC accumulator output, sign-magnitude
- resultValid  out  1  resultOut/resultNeuron valid
- resultReady  in  1  consumer accepts result
- resultOut  out  21  captured neuron sum, sign-magnitude, unmodified
- resultNeuron  out  NEURON_W  index of neuron in resultOut

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs 0: busy, done, macInit, macEn, resultValid, dataAddr, weightAddr, resultOut, resultNeuron. Internal counters 0. Reset aborts any operation in any state; no done is issued for the aborted layer.
- Memory model: an address driven in cycle t yields data/weight at the MAC inputs in cycle t+1. macEn in cycle t updates macResult visibly at t+1.
- States:
  - IDLE: start=1 -> CLEAR, with neuron=0, base=0.
  - CLEAR (1 cycle): macInit=1, macEn=0. dataAddr=0, weightAddr=base. -> FETCH with k=0.
  - FETCH (N_INPUTS cycles, k=0..N_INPUTS-1): macEn=1, products for input k accumulate. dataAddr=k+1, weightAddr=base+k+1 (don't-care when k=N_INPUTS-1). After k=N_INPUTS-1 -> LATCH.
  - LATCH (1 cycle): macEn=0. resultOut<=macResult, resultNeuron<=neuron at this edge. -> PRESENT.
  - PRESENT: resultValid=1. resultOut and resultNeuron stable until handshake (resultValid & resultReady at an edge). On handshake: if neuron==N_NEURONS-1 -> DONE, else neuron+=1, base+=N_INPUTS, -> CLEAR.
  - DONE (1 cycle): done=1. -> IDLE.
- macInit and macEn are never both 1. All control outputs are registered or decoded from state only, with no combinational path from resultReady.
- weightAddr = neuron*N_INPUTS + index, implemented by a running base adder; no multiplier.
- Per-neuron latency with resultReady held 1: N_INPUTS+3 cycles (CLEAR + FETCH + LATCH + 1 PRESENT). Layer: N_NEURONS*(N_INPUTS+3)+1 cycles from start accepted to done.
- start while busy=1 is ignored. start=1 in the DONE cycle is ignored; it is honoured only once back in IDLE.
- resultReady=0 stalls indefinitely in PRESENT. MAC is not enabled while stalled, so macResult is held.
- resultValid drops the cycle after the handshake. It is never high outside PRESENT.

Test Plan:
- N_INPUTS=4, N_NEURONS=2, resultReady=1, data={1,2,3,4}, weights n0={1,1,1,1}, n1={-2,0,0,1} (sign-mag) -> results 10 (n0), then -2+4=+2 (n1). resultValid high once per neuron. done pulses at cycle 15 after start. busy high 15 cycles.
- Address trace, same config -> CLEAR/FETCH dataAddr 0,1,2,3,4. weightAddr 0..4 for n0 and 4..8 for n1. macInit exactly 1 cycle before each 4-cycle macEn burst.
- Backpressure: resultReady=0 for 5 cycles in n0 PRESENT -> resultOut=10, resultNeuron=0 held stable. No macEn/macInit during stall. Next CLEAR starts the cycle after ready rises.
- rst=1 asserted mid-FETCH of n1 -> next cycle all outputs 0, state IDLE, no done. A new start then produces n0 result 10 again.
- start pulsed during FETCH and during DONE -> ignored: exactly one layer run, one done pulse.
- N_NEURONS=1, data all 127, weights all -127 -> resultOut = -(4*16129) = sign bit 1, magnitude 64516. done follows the single handshake.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: steps one sign-magnitude MAC unit through a fully-connected layer.
//
// For every neuron the accumulator is cleared, all N_INPUTS data/weight pairs are streamed
// from the input buffer and weight ROM (1-cycle read latency), and the 21b sum is captured.
// The sum is then offered to the activation stage on a valid/ready port. After the last
// neuron's handshake, done pulses for one cycle.
//
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   start         begin a layer; only looked at while idle
//   busy          high in every state except idle
//   done          one-cycle pulse after the last neuron's result handshake
//   dataAddr      input buffer read address
//   weightAddr    weight ROM read address (neuron*N_INPUTS + index)
//   macInit       clears the MAC accumulator
//   macEn         accumulates the product currently at the MAC inputs
//   macResult     MAC accumulator output (sign-magnitude)
//   resultValid   resultOut/resultNeuron valid
//   resultReady   consumer accepts the result
//   resultOut     captured neuron sum, passed through unmodified
//   resultNeuron  index of the neuron held in resultOut
//
// Every output is a flop. Control outputs are decoded from the next state, so they line up
// with the state register and never depend combinationally on resultReady.

module mac_sequencer #(
  parameter int unsigned N_INPUTS  = 64,
  parameter int unsigned N_NEURONS = 10,
  parameter int unsigned DATA_AW   = 6,
  parameter int unsigned WEIGHT_AW = 10,
  parameter int unsigned NEURON_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_AW-1:0]   dataAddr,
  output logic [WEIGHT_AW-1:0] weightAddr,
  output logic                 macInit,
  output logic                 macEn,
  input  logic [20:0]          macResult,
  output logic                 resultValid,
  input  logic                 resultReady,
  output logic [20:0]          resultOut,
  output logic [NEURON_W-1:0]  resultNeuron
);

  localparam int unsigned KW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [KW-1:0]        KLast      = KW'(N_INPUTS - 1);
  localparam logic [KW-1:0]        KOne       = KW'(1);
  localparam logic [NEURON_W-1:0]  NeuronLast = NEURON_W'(N_NEURONS - 1);
  localparam logic [NEURON_W-1:0]  NeuronOne  = NEURON_W'(1);
  localparam logic [WEIGHT_AW-1:0] BaseStep   = WEIGHT_AW'(N_INPUTS);
  localparam logic [WEIGHT_AW-1:0] WeightOne  = WEIGHT_AW'(1);
  localparam logic [DATA_AW-1:0]   DataOne    = DATA_AW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StLatch,
    StPresent,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [NEURON_W-1:0]   neuron_q, neuron_d;
  logic [WEIGHT_AW-1:0]  base_q, base_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mac_init_q, mac_init_d;
  logic                  mac_en_q, mac_en_d;
  logic                  valid_q, valid_d;
  logic [DATA_AW-1:0]    data_addr_q, data_addr_d;
  logic [WEIGHT_AW-1:0]  weight_addr_q, weight_addr_d;
  logic [20:0]           result_q, result_d;
  logic [NEURON_W-1:0]   result_neuron_q, result_neuron_d;

  // Next-state, counters and address generation.
  // Addresses run one step ahead of the accumulation because of the 1-cycle read latency:
  // CLEAR issues index 0, FETCH k issues index k+1 while the product of index k accumulates.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    neuron_d        = neuron_q;
    base_d          = base_q;
    data_addr_d     = data_addr_q;
    weight_addr_d   = weight_addr_q;
    result_d        = result_q;
    result_neuron_d = result_neuron_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StClear;
          neuron_d      = '0;
          base_d        = '0;
          data_addr_d   = '0;
          weight_addr_d = '0;
        end
      end

      StClear: begin
        state_d       = StFetch;
        k_d           = '0;
        data_addr_d   = data_addr_q + DataOne;
        weight_addr_d = weight_addr_q + WeightOne;
      end

      StFetch: begin
        if (k_q == KLast) begin
          // Address issued here would be past the neuron; leave it, it is never consumed.
          state_d = StLatch;
        end else begin
          k_d           = k_q + KOne;
          data_addr_d   = data_addr_q + DataOne;
          weight_addr_d = weight_addr_q + WeightOne;
        end
      end

      StLatch: begin
        // The final product became visible on macResult this cycle.
        state_d         = StPresent;
        result_d        = macResult;
        result_neuron_d = neuron_q;
      end

      StPresent: begin
        if (resultReady) begin
          if (neuron_q == NeuronLast) begin
            state_d = StDone;
          end else begin
            state_d       = StClear;
            neuron_d      = neuron_q + NeuronOne;
            // Running base replaces a neuron*N_INPUTS multiply.
            base_d        = base_q + BaseStep;
            data_addr_d   = '0;
            weight_addr_d = base_q + BaseStep;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control outputs are decoded from the state being entered, so the registered copies
  // are aligned with state_q in the following cycle.
  always_comb begin
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    mac_init_d = (state_d == StClear);
    mac_en_d   = (state_d == StFetch);
    valid_d    = (state_d == StPresent);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      k_q             <= '0;
      neuron_q        <= '0;
      base_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mac_init_q      <= 1'b0;
      mac_en_q        <= 1'b0;
      valid_q         <= 1'b0;
      data_addr_q     <= '0;
      weight_addr_q   <= '0;
      result_q        <= '0;
      result_neuron_q <= '0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      neuron_q        <= neuron_d;
      base_q          <= base_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      mac_init_q      <= mac_init_d;
      mac_en_q        <= mac_en_d;
      valid_q         <= valid_d;
      data_addr_q     <= data_addr_d;
      weight_addr_q   <= weight_addr_d;
      result_q        <= result_d;
      result_neuron_q <= result_neuron_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign macInit      = mac_init_q;
  assign macEn        = mac_en_q;
  assign resultValid  = valid_q;
  assign dataAddr     = data_addr_q;
  assign weightAddr   = weight_addr_q;
  assign resultOut    = result_q;
  assign resultNeuron = result_neuron_q;

`ifndef SYNTHESIS
  // Clearing and accumulating in the same cycle would corrupt the sum.
  a_init_en_excl: assert property (@(posedge clk) disable iff (rst) !(macInit && macEn));
  // The result port is only ever driven while presenting.
  a_valid_in_present: assert property (@(posedge clk) disable iff (rst)
                                       resultValid |-> (state_q == StPresent));
  // Held result must not move while the consumer stalls.
  a_result_stable: assert property (@(posedge clk) disable iff (rst)
                                    (resultValid && !resultReady) |=>
                                    ($stable(resultOut) && $stable(resultNeuron)));
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: small layer (4 inputs, 2 neurons) with a behavioural input buffer,
// weight ROM and sign-magnitude MAC around the DUT. Expected neuron sums come from plain
// dot products over the memory contents and are queued at start; a monitor pops and compares
// on every result handshake.

module tb_mac_sequencer;

  localparam int NI  = 4;
  localparam int NN  = 2;
  localparam int DAW = 3;
  localparam int WAW = 4;
  localparam int NW  = 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic [DAW-1:0] dataAddr;
  logic [WAW-1:0] weightAddr;
  logic           macInit;
  logic           macEn;
  logic [20:0]    macResult;
  logic           resultValid;
  logic           resultReady;
  logic [20:0]    resultOut;
  logic [NW-1:0]  resultNeuron;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [NW-1:0] neuron;
    logic [20:0]   value;
  } exp_t;

  exp_t exp_q[$];

  mac_sequencer #(
    .N_INPUTS (NI),
    .N_NEURONS(NN),
    .DATA_AW  (DAW),
    .WEIGHT_AW(WAW),
    .NEURON_W (NW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .dataAddr    (dataAddr),
    .weightAddr  (weightAddr),
    .macInit     (macInit),
    .macEn       (macEn),
    .macResult   (macResult),
    .resultValid (resultValid),
    .resultReady (resultReady),
    .resultOut   (resultOut),
    .resultNeuron(resultNeuron)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int smval(input logic [7:0] b);
    return b[7] ? -int'(b[6:0]) : int'(b[6:0]);
  endfunction

  function automatic logic [20:0] to_sm21(input int v);
    if (v < 0) return {1'b1, 20'(-v)};
    return {1'b0, 20'(v)};
  endfunction

  // Environment: memories with one cycle of read latency feeding an accumulating MAC.
  logic [7:0] data_mem [8];
  logic [7:0] w_rom    [16];
  logic [7:0] d_rd;
  logic [7:0] w_rd;
  int         acc = 0;

  always @(posedge clk) begin
    d_rd <= data_mem[dataAddr];
    w_rd <= w_rom[weightAddr];
    if (macInit)    acc <= 0;
    else if (macEn) acc <= acc + smval(d_rd) * smval(w_rd);
  end

  assign macResult = to_sm21(acc);

  // Reference: neuron n's sum is the dot product of the data buffer with ROM row n.
  function automatic logic [20:0] exp_sum(input int n);
    int s = 0;
    for (int i = 0; i < NI; i++) s += smval(data_mem[i]) * smval(w_rom[n * NI + i]);
    return to_sm21(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push_layer();
    exp_t e;
    for (int n = 0; n < NN; n++) begin
      e.neuron = NW'(n);
      e.value  = exp_sum(n);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: sampled on the falling edge, between input changes and the next active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (macInit && macEn) check("init_en_exclusive", 1, 0);
      if (resultValid && (macInit || macEn)) check("mac_idle_while_valid", 1, 0);
      if (resultValid && resultReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result_neuron", 32'(resultNeuron), 32'(e.neuron));
          check("result_value", 32'(resultOut), 32'(e.value));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_macInit"}, macInit, 0);
    check({tag, "_macEn"}, macEn, 0);
    check({tag, "_valid"}, resultValid, 0);
    check({tag, "_dataAddr"}, 32'(dataAddr), 0);
    check({tag, "_weightAddr"}, 32'(weightAddr), 0);
    check({tag, "_resultOut"}, 32'(resultOut), 0);
    check({tag, "_resultNeuron"}, 32'(resultNeuron), 0);
  endtask

  task automatic wait_done(input bit rand_rdy, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rand_rdy) resultReady = 1'($urandom_range(0, 1));
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    resultReady = 1'b1;
    check("done_within_budget", 32'(seen), 1);
  endtask

  task automatic run_layer(input bit rand_rdy);
    int d0 = done_cnt;
    check("idle_before_start", busy, 0);
    push_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(rand_rdy, 400);
    tick();
    check("busy_after_done", busy, 0);
    check("one_done_per_layer", 32'(done_cnt - d0), 1);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
  endtask

  // Cycle c after the start edge (c = 1 is the first CLEAR), all ready-high timing.
  task automatic trace_check(input int c);
    int  per = NI + 3;
    int  n;
    int  p;
    bit  e_busy  = 1'b0;
    bit  e_done  = 1'b0;
    bit  e_init  = 1'b0;
    bit  e_en    = 1'b0;
    bit  e_valid = 1'b0;
    if (c <= NN * per) begin
      n       = (c - 1) / per;
      p       = (c - 1) % per;
      e_busy  = 1'b1;
      e_init  = (p == 0);
      e_en    = (p >= 1) && (p <= NI);
      e_valid = (p == NI + 2);
      if (p <= NI) begin
        check("trace_dataAddr", 32'(dataAddr), 32'(p));
        check("trace_weightAddr", 32'(weightAddr), 32'(n * NI + p));
      end
    end else if (c == NN * per + 1) begin
      e_busy = 1'b1;
      e_done = 1'b1;
    end
    check("trace_busy", busy, 32'(e_busy));
    check("trace_done", done, 32'(e_done));
    check("trace_macInit", macInit, 32'(e_init));
    check("trace_macEn", macEn, 32'(e_en));
    check("trace_valid", resultValid, 32'(e_valid));
  endtask

  task automatic load_directed();
    for (int i = 0; i < 8; i++) data_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) w_rom[i] = 8'h00;
    data_mem[0] = 8'd1; data_mem[1] = 8'd2; data_mem[2] = 8'd3; data_mem[3] = 8'd4;
    w_rom[0] = 8'd1; w_rom[1] = 8'd1; w_rom[2] = 8'd1; w_rom[3] = 8'd1;
    w_rom[4] = 8'h82; w_rom[5] = 8'h00; w_rom[6] = 8'h00; w_rom[7] = 8'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int  d0;
    bit  seen;

    rst         = 1'b1;
    start       = 1'b0;
    resultReady = 1'b1;
    load_directed();
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_after_reset", busy, 0);

    // Directed layer with full cycle-by-cycle trace: sums 10 and +2.
    d0 = done_cnt;
    push_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= NN * (NI + 3) + 2; c++) begin
      trace_check(c);
      tick();
    end
    check("trace_one_done", 32'(done_cnt - d0), 1);
    check("trace_drained", 32'(exp_q.size()), 0);

    // Backpressure on neuron 0: result held, MAC quiet, CLEAR right after the handshake.
    resultReady = 1'b0;
    push_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (resultValid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("stall_valid_seen", 32'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_resultOut", 32'(resultOut), 10);
      check("stall_resultNeuron", 32'(resultNeuron), 0);
      check("stall_valid", resultValid, 1);
      check("stall_macEn", macEn, 0);
      check("stall_macInit", macInit, 0);
      tick();
    end
    resultReady = 1'b1;
    tick();
    check("post_stall_clear", macInit, 1);
    check("post_stall_valid_low", resultValid, 0);
    wait_done(1'b0, 40);
    tick();
    check("stall_drained", 32'(exp_q.size()), 0);

    // Reset during FETCH of neuron 1 aborts the layer without a done pulse.
    push_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("abort_in_fetch", macEn, 1);
    d0  = done_cnt;
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_zero("abort");
    rst = 1'b0;
    repeat (25) tick();
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_idle", busy, 0);
    run_layer(1'b0);

    // start during FETCH and during DONE is ignored.
    d0 = done_cnt;
    push_layer();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, 40);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore_start_in_done", busy, 0);
    repeat (5) tick();
    check("ignore_still_idle", busy, 0);
    check("ignore_one_done", 32'(done_cnt - d0), 1);
    check("ignore_drained", 32'(exp_q.size()), 0);

    // Largest magnitudes: 4 * (127 * -127) = -64516.
    for (int i = 0; i < NI; i++) data_mem[i] = 8'h7F;
    for (int i = 0; i < NN * NI; i++) w_rom[i] = 8'hFF;
    run_layer(1'b0);
    check("extreme_resultOut", 32'(resultOut), 32'({1'b1, 20'd64516}));

    // Random contents with random backpressure.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NI; i++) data_mem[i] = 8'($urandom);
      for (int i = 0; i < NN * NI; i++) w_rom[i] = 8'($urandom);
      run_layer(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
